// File: rtl/ucu_pkg.sv
// Shared encodings for the 4-bit core control unit: FSM states, opcodes,
// control-word bit positions and ALU operation codes.
package ucu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        HALT   = 3'd3,
        PAUSE  = 3'd4
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_CLR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CTL_ACC_CLR = 15;
    localparam int CTL_ACC_LD  = 14;
    localparam int CTL_FLAG_LD = 13;
    localparam int CTL_ALU_LSB = 10;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;
    localparam logic [2:0] ALU_OR     = 3'b100;
    localparam logic [2:0] ALU_XOR    = 3'b101;

    // Arithmetic/logic ops all load the accumulator and capture flags.
    function automatic logic [15:0] alu_ctl(input logic [2:0] op);
        logic [15:0] w;
        w = '0;
        w[CTL_ACC_LD]         = 1'b1;
        w[CTL_FLAG_LD]        = 1'b1;
        w[CTL_ALU_LSB +: 3]   = op;
        return w;
    endfunction

endpackage

// File: rtl/ucu_decoder.sv
// Combinational instruction decoder: opcode plus latched flags produce the
// EXEC control word, the jump decision and the halt request.
module ucu_decoder
    import ucu_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic        z_i,
    input  logic        c_i,
    output logic [15:0] control_o,
    output logic        jump_take_o,
    output logic        halt_req_o
);

    always_comb begin
        control_o   = '0;
        jump_take_o = 1'b0;
        halt_req_o  = 1'b0;
        case (opcode_i)
            OP_LDI: begin
                control_o[CTL_ACC_LD]       = 1'b1;
                control_o[CTL_ALU_LSB +: 3] = ALU_PASS_B;
            end
            OP_ADD: control_o = alu_ctl(ALU_ADD);
            OP_SUB: control_o = alu_ctl(ALU_SUB);
            OP_AND: control_o = alu_ctl(ALU_AND);
            OP_OR:  control_o = alu_ctl(ALU_OR);
            OP_XOR: control_o = alu_ctl(ALU_XOR);
            OP_CLR: control_o[CTL_ACC_CLR] = 1'b1;
            OP_JMP: jump_take_o = 1'b1;
            OP_JZ:  jump_take_o = z_i;
            OP_JC:  jump_take_o = c_i;
            OP_HLT: halt_req_o  = 1'b1;
            default: ;  // NOP and the illegal opcodes B..E do nothing
        endcase
    end

endmodule

// File: rtl/ucu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC control unit owning PC, IR and the Z/C flags.
// Define UCU_SINGLE_STEP_EN to add the step input and a PAUSE state after each EXEC.
module ucu_sequencer
    import ucu_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_valid,
    input  logic [7:0]        imem_data,
    input  logic              z_in,
    input  logic              c_in,
    output logic [15:0]       control,
    output logic [3:0]        imm,
`ifdef UCU_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              halted
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [ADDR_W-1:0] pc_jmp_d;
    logic [7:0]        ir_q;
    logic              z_q, c_q;
    logic [15:0]       control_q;
    logic              halted_q;

    logic [15:0]       dec_ctl;
    logic              jump_take;
    logic              halt_req;

    ucu_decoder u_dec (
        .opcode_i    (ir_q[7:4]),
        .z_i         (z_q),
        .c_i         (c_q),
        .control_o   (dec_ctl),
        .jump_take_o (jump_take),
        .halt_req_o  (halt_req)
    );

    assign pc_inc_d = pc_q + ADDR_W'(1);
    // Jumps stay within the current 16-word page.
    assign pc_jmp_d = {pc_q[ADDR_W-1:4], ir_q[3:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            pc_q      <= ADDR_W'(RESET_PC);
            ir_q      <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            control_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (run && imem_valid) begin
                        ir_q    <= imem_data;
                        pc_q    <= pc_inc_d;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    control_q <= dec_ctl;
                    state_q   <= EXEC;
                end
                EXEC: begin
                    control_q <= '0;
                    if (control_q[CTL_FLAG_LD]) begin
                        z_q <= z_in;
                        c_q <= c_in;
                    end else if (control_q[CTL_ACC_CLR]) begin
                        z_q <= 1'b1;
                        c_q <= 1'b0;
                    end
                    if (jump_take)
                        pc_q <= pc_jmp_d;
                    if (halt_req) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else begin
`ifdef UCU_SINGLE_STEP_EN
                        state_q <= PAUSE;
`else
                        state_q <= FETCH;
`endif
                    end
                end
`ifdef UCU_SINGLE_STEP_EN
                PAUSE: begin
                    if (step)
                        state_q <= FETCH;
                end
`endif
                default: ;  // HALT is left only through reset
            endcase
        end
    end

    // Request tracks run combinationally so a dropped run withdraws it at once.
    assign imem_req  = reset_n & run & (state_q == FETCH);
    assign imem_addr = pc_q;
    assign control   = control_q;
    assign imm       = ir_q[3:0];
    assign halted    = halted_q;

endmodule

// File: tb/tb_ucu_sequencer.sv
// Scoreboard bench for ucu_sequencer: an ISA-level model predicts fetch
// addresses and EXEC control words/cycles; a negedge monitor checks them.
module tb_ucu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        run = 1'b0;
    logic        imem_valid = 1'b0;
    logic [7:0]  imem_data = 8'h00;
    logic        z_in = 1'b0, c_in = 1'b0;
    logic        step = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] control;
    logic [3:0]  imm;
    logic        halted;

    always #5 clk = ~clk;

    ucu_sequencer #(.ADDR_W(8), .RESET_PC(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .z_in       (z_in),
        .c_in       (c_in),
        .control    (control),
        .imm        (imm),
`ifdef UCU_SINGLE_STEP_EN
        .step       (step),
`endif
        .halted     (halted)
    );

`ifdef UCU_SINGLE_STEP_EN
    localparam int PAUSE_CYC = 1;
`else
    localparam int PAUSE_CYC = 0;
`endif

    typedef struct {
        logic [15:0] ctl;
        logic [3:0]  im;
        int          cyc;
    } exec_t;

    exec_t       exec_q[$];
    int          fetch_q[$];
    logic [7:0]  mem [0:255];
    int          waits [0:299];
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0;
    bit          mon_en = 1'b1;
    bit          force_v = 1'b0;
    int          rid = 0, limit = 0, served = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory responder: serves `limit` fetches per run, each after waits[i] cycles.
    initial begin
        int seen = 0, wcnt = 0;
        forever begin
            @(negedge clk);
            if (rid != seen) begin seen = rid; served = 0; wcnt = 0; end
            if (force_v) begin
                imem_valid = 1'b1; imem_data = 8'h15;
            end else if (imem_req && served < limit) begin
                if (wcnt >= waits[served]) begin
                    imem_valid = 1'b1; imem_data = mem[imem_addr];
                    served++; wcnt = 0;
                end else begin
                    imem_valid = 1'b0; wcnt++;
                end
            end else begin
                imem_valid = 1'b0; imem_data = 8'($urandom);
            end
        end
    end

    // Monitor: cycle 1 is the first cycle with run high.
    initial begin
        forever begin
            @(negedge clk); #1;
            if (!run) cyc = 0; else cyc++;
            if (mon_en) begin
                if (imem_req && imem_valid) begin
                    if (fetch_q.size() == 0) chk("fetch_unexpected", {24'h0, imem_addr}, 32'hFFFF_FFFF);
                    else chk("fetch_addr", {24'h0, imem_addr}, fetch_q.pop_front());
                end
                if (control != 16'h0) begin
                    if (exec_q.size() == 0) chk("exec_unexpected", {16'h0, control}, 32'h0);
                    else begin
                        exec_t e;
                        e = exec_q.pop_front();
                        chk("exec_ctl", {16'h0, control}, {16'h0, e.ctl});
                        chk("exec_imm", {28'h0, imm}, {28'h0, e.im});
                        chk("exec_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic do_rst();
        run = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_control", {16'h0, control}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_imm", {28'h0, imm}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h0);
        @(posedge clk); #3;
        reset_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic set_waits(input int maxw);
        for (int i = 0; i < 300; i++) waits[i] = (maxw == 0) ? 0 : int'($urandom_range(maxw, 0));
    endtask

    // ISA-level model of one program run from PC=0 with cleared flags.
    task automatic run_prog(input int maxi, input bit zi, input bit ci, input bit rst);
        int pc, t, ex, op, im, nf, ctl;
        bit z, c, hl, ok;
        if (rst) do_rst();
        z_in = zi; c_in = ci;
        pc = 0; z = 0; c = 0; t = 1; hl = 0; nf = 0;
        for (int i = 0; i < maxi && !hl; i++) begin
            op = int'(mem[pc][7:4]); im = int'(mem[pc][3:0]);
            fetch_q.push_back(pc);
            pc = (pc + 1) % 256;
            ex = t + waits[i] + 2;
            ctl = 0;
            if (op == 1) ctl = 'h4000;
            else if (op >= 2 && op <= 6) begin ctl = 'h6000 + ((op - 1) * 1024); z = zi; c = ci; end
            else if (op == 7) begin ctl = 'h8000; z = 1; c = 0; end
            else if (op == 8 || (op == 9 && z) || (op == 10 && c)) pc = (pc / 16) * 16 + im;
            else if (op == 15) hl = 1;
            if (ctl != 0) exec_q.push_back('{ctl[15:0], im[3:0], ex});
            t = ex + 1 + PAUSE_CYC;
            nf = i + 1;
        end
        rid++; limit = nf;
        @(posedge clk); #1;
        run = 1'b1;
        ok = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk); #2;
            if ((hl ? halted : (served == limit)) && exec_q.size() == 0 && fetch_q.size() == 0) begin
                ok = 1; break;
            end
        end
        chk("run_complete", {31'h0, ok}, 32'h1);
        repeat (4) @(negedge clk);
        #2;
        chk("end_halted", {31'h0, halted}, {31'h0, hl});
        chk("end_pc", {24'h0, imem_addr}, pc);
        chk("end_req", {31'h0, imem_req}, {31'h0, !hl});
        @(posedge clk); #1;
        run = 1'b0;
        exec_q.delete(); fetch_q.delete();
    endtask

    initial begin
        bit found;
        // LDI 5; ADD 3; HLT with zero-wait memory
        clear_mem(); set_waits(0);
        mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'hF0;
        run_prog(10, 1'b0, 1'b1, 1'b1);

        // CLR; JZ 4 -> HLT at 4
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'h94; mem[2] = 8'h11; mem[4] = 8'hF0;
        run_prog(10, 1'b0, 1'b0, 1'b1);

        // SUB; JC 9 with carry set and clear
        clear_mem();
        mem[0] = 8'h31; mem[1] = 8'hA9; mem[2] = 8'hF0; mem[9] = 8'hF0;
        run_prog(10, 1'b0, 1'b1, 1'b1);
        run_prog(10, 1'b0, 1'b0, 1'b1);

        // run dropped while waiting: req follows run, late valid ignored
        do_rst();
        rid++; limit = 0;
        @(posedge clk); #1;
        run = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("drop_req_hi", {31'h0, imem_req}, 32'h1);
        @(posedge clk); #1;
        run = 1'b0;
        #1;
        chk("drop_req_lo", {31'h0, imem_req}, 32'h0);
        force_v = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("drop_ir_held", {28'h0, imm}, 32'h0);
        chk("drop_pc_held", {24'h0, imem_addr}, 32'h0);
        chk("drop_ctl_zero", {16'h0, control}, 32'h0);
        force_v = 1'b0;
        @(negedge clk);
        clear_mem(); set_waits(3);
        mem[0] = 8'h1A; mem[1] = 8'h47; mem[2] = 8'hF0;
        run_prog(10, 1'b1, 1'b0, 1'b0);

        // PC wrap through 0xFF, illegal opcode at 0xFE
        clear_mem(); set_waits(0);
        mem[0] = 8'h19; mem[8'hFE] = 8'hC3;
        run_prog(258, 1'b0, 1'b0, 1'b1);

        // reset asserted during EXEC of ADD
        do_rst();
        clear_mem(); set_waits(0);
        mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'hF0;
        mon_en = 1'b0;
        rid++; limit = 3;
        @(posedge clk); #1;
        run = 1'b1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #2;
            if (control == 16'h6400) begin found = 1; break; end
        end
        chk("mid_exec_seen", {31'h0, found}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {16'h0, control}, 32'h0);
        chk("mid_rst_pc", {24'h0, imem_addr}, 32'h0);
        run = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        run_prog(10, 1'b0, 1'b0, 1'b0);

        // random programs with random memory latency
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            set_waits(3);
            run_prog(40, 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ucu_sequencer.md
Name: ucu_sequencer

Overview:
- Multi-cycle control unit for the 4-bit microcontroller core.
- Owns PC and IR, and fetches 8-bit instructions over a valid handshake: opcode[7:4], imm[3:0].
- Decodes each instruction and drives the 16-bit datapath control word for one EXEC cycle. This word drives the accumulator clear/load and the ALU op.
- Sits between instruction memory and the ALU/accumulator datapath; latches ALU flags for conditional jumps.

Parameters:
- ADDR_W, 8, PC / instruction-address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  level; when 0, no new fetch is issued.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_req  out  1  fetch request.
- imem_valid  in  1  instruction valid; sampled only while imem_req=1.
- imem_data  in  8  instruction.
- z_in  in  1  ALU zero flag (combinational from datapath).
- c_in  in  1  ALU carry flag.
- control  out  16  datapath control word, registered.
- imm  out  4  IR[3:0] operand to ALU B input.
- halted  out  1  high in HALT.
- step  in  1  single-step pulse; present only with UCU_SINGLE_STEP_EN.

Behaviour:
- Reset (async, reset_n=0):
  - State=FETCH, PC=RESET_PC, IR=0, flags Z/C=0.
  - control=16'h0000, imem_req=0, imm=0, halted=0.
- Control word bits:
  - [15] ACC_CLR.
  - [14] ACC_LD.
  - [13] FLAG_LD.
  - [12:10] ALU_OP: 000 PASS_B, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR.
  - [9:0] reserved, always 0.
  - Shared package constants define all bit positions and ALU_OP codes.
- FETCH:
  - imem_req = run.
  - On imem_req & imem_valid: IR<=imem_data, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0), go to DECODE.
  - Otherwise stay.
  - run falling while waiting drops imem_req; a late imem_valid is ignored.
- DECODE: 1 cycle; registers the control word for EXEC; goes to EXEC.
- EXEC: 1 cycle, control held stable the whole cycle so the negedge-clocked accumulator captures mid-cycle. Opcodes:
  - 0 NOP: control=0.
  - 1 LDI: ACC_LD, PASS_B.
  - 2 ADD / 3 SUB / 4 AND / 5 OR / 6 XOR: ACC_LD, FLAG_LD, matching ALU_OP.
  - 7 CLR: ACC_CLR, plus Z<=1, C<=0.
  - 8 JMP: PC<={PC[ADDR_W-1:4],imm}.
  - 9 JZ: jump if latched Z.
  - A JC: jump if latched C.
  - F HLT: go to HALT.
  - B–E illegal: execute as NOP.
  - With FLAG_LD, Z<=z_in and C<=c_in at the posedge ending EXEC.
- After EXEC (non-HLT): control<=0, go to FETCH.
- Latency: zero-wait memory gives 3 cycles/instruction (FETCH, DECODE, EXEC). Each extra memory wait cycle adds 1.
- HALT: control=0, imem_req=0, halted=1. Left only by reset.
- Jump and PC increment in the same instruction: the jump target overrides; the increment already occurred in FETCH.
- control is nonzero only in EXEC; ACC_CLR and ACC_LD are never both set.
- Reset mid-EXEC clears control immediately (async).

Optional Feature:
- UCU_SINGLE_STEP_EN defined:
  - Adds the step port and a PAUSE state entered after every non-HLT EXEC.
  - A 1-cycle step pulse moves PAUSE->FETCH. While in PAUSE, control=0 and imem_req=0.
  - step while not in PAUSE is ignored.
- Not defined: no step port, no PAUSE state; EXEC goes straight to FETCH.

Decomposition:
- ucu_pkg holds:
  - state enum (FETCH, DECODE, EXEC, HALT, PAUSE);
  - opcode localparams;
  - control-bit index constants;
  - ALU_OP codes.
- One sub-module, ucu_decoder: combinational opcode + flags -> control word, jump_take and halt_req.

Test Plan:
- Reset, then program LDI 5; ADD 3; HLT at addr 0..2, zero-wait -> control=16'h4000 with imm=5 in cycle 3, then 16'h6400 with imm=3 in cycle 6; halted=1 after cycle 9; PC=3.
- CLR then JZ 4 -> control=16'h8000 in EXEC; next imem_addr=0x04.
- SUB with c_in=1 then JC 9; rerun with c_in=0 -> PC=0x09 when taken, PC advances sequentially when not taken.
- imem_valid delayed 2 cycles, then run dropped mid-FETCH -> imem_req follows run; IR unchanged until a valid arrives with req high.
- PC=0xFF fetches NOP -> PC wraps to 0x00; opcode 0xC -> control=0 throughout.
- reset_n asserted in EXEC of ADD -> control=0 immediately; PC=RESET_PC; restart fetches addr 0.
- With UCU_SINGLE_STEP_EN: after LDI, control=0 and no fetch until step pulse; fetch resumes 1 cycle after the pulse.
